// File: rtl/mul_share_ctrl_if.sv
// Requester/multiplier bundle for the shared-multiplier scheduler.
// The slave side is the scheduler; the master side drives requests and the multiplier returns.
interface mul_share_ctrl_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              err;
    logic [2*W-1:0]    result;
    logic              ctrl_busy;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_busy;
    logic [W:0]        mul_hreg;
    logic [W-1:0]      mul_lreg;

    modport master (
        output req, req_a, req_b, mul_busy, mul_hreg, mul_lreg,
        input  gnt, done, err, result, ctrl_busy, mul_start, mul_a, mul_b
    );

    modport slave (
        input  req, req_a, req_b, mul_busy, mul_hreg, mul_lreg,
        output gnt, done, err, result, ctrl_busy, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin scheduler sharing one shift-add multiplier among NREQ requesters,
// with a watchdog on the multiplier start/busy handshake.
module mul_share_ctrl #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned TMO_HI  = 4,
    parameter int unsigned TMO_RUN = 2*W+4
) (
    input  logic           clk,
    input  logic           rst,
    mul_share_ctrl_if.slave bus
);
    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TMAX = (TMO_RUN > TMO_HI) ? TMO_RUN : TMO_HI;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_HI, RUN, RESP} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic [2*W-1:0]  result_q, result_d;
    logic [2*W-1:0]  prod_q, prod_d;
    logic            fault_q, fault_d;
    logic            start_q, start_d;
    logic [W-1:0]    mul_a_q, mul_a_d;
    logic [W-1:0]    mul_b_q, mul_b_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [IW-1:0]   rr_last_q, rr_last_d;
    logic            cbusy_q, cbusy_d;

    logic [W-1:0]    op_a [NREQ];
    logic [W-1:0]    op_b [NREQ];
    logic [IW-1:0]   cand;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;

    // Unpack the flattened operand buses into per-requester slots.
    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            op_a[i] = bus.req_a[i*W +: W];
            op_b[i] = bus.req_b[i*W +: W];
        end
    end

    // First set request searching upward from the slot after the last winner.
    always_comb begin
        cand     = '0;
        pick_vld = 1'b0;
        pick_idx = rr_last_q;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = IW'((int'(rr_last_q) + k) % int'(NREQ));
            if (!pick_vld && bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        err_d     = 1'b0;
        result_d  = result_q;
        prod_d    = prod_q;
        fault_d   = fault_q;
        start_d   = start_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        timer_d   = timer_q;
        rr_last_d = rr_last_q;

        unique case (state_q)
            IDLE: begin
                start_d = 1'b0;
                if (pick_vld) begin
                    gnt_d     = NREQ'(1) << pick_idx;
                    mul_a_d   = op_a[pick_idx];
                    mul_b_d   = op_b[pick_idx];
                    rr_last_d = pick_idx;
                    fault_d   = 1'b0;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                start_d = 1'b1;
                timer_d = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.mul_busy) begin
                    timer_d = '0;
                    state_d = RUN;
                end else if (timer_q == TW'(TMO_HI - 1)) begin
                    fault_d = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RUN: begin
                if (!bus.mul_busy) begin
                    prod_d  = {bus.mul_hreg[W-1:0], bus.mul_lreg};
                    state_d = RESP;
                end else if (timer_q == TW'(TMO_RUN - 1)) begin
                    fault_d = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                done_d   = NREQ'(1) << rr_last_q;
                err_d    = fault_q;
                result_d = fault_q ? '0 : prod_q;
                start_d  = 1'b0;
                gnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cbusy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            result_q  <= '0;
            prod_q    <= '0;
            fault_q   <= 1'b0;
            start_q   <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            timer_q   <= '0;
            rr_last_q <= IW'(NREQ - 1);
            cbusy_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            result_q  <= result_d;
            prod_q    <= prod_d;
            fault_q   <= fault_d;
            start_q   <= start_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            timer_q   <= timer_d;
            rr_last_q <= rr_last_d;
            cbusy_q   <= cbusy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.result    = result_q;
    assign bus.ctrl_busy = cbusy_q;
    assign bus.mul_start = start_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a behavioural 8-bit shift-add multiplier
// (one init cycle, then alternating add/shift cycles) and stuck-busy fault modes.
module tb_mul_share_ctrl;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mode    = 0;

    always #5 clk = ~clk;

    mul_share_ctrl_if #(.NREQ(NREQ), .W(W)) bus ();

    mul_share_ctrl #(.NREQ(NREQ), .W(W), .TMO_HI(4), .TMO_RUN(2*W+4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [8:0] m_h   = '0;
    logic [7:0] m_l   = '0;
    logic [4:0] m_cnt = '0;
    logic       m_busy = 1'b0;

    // Multiplier model: odd steps add, even steps shift, 16 steps total.
    always_ff @(posedge clk) begin
        if (!bus.mul_start) begin
            m_busy <= 1'b0;
            m_cnt  <= '0;
        end else if (m_cnt == 5'd0) begin
            m_h    <= '0;
            m_l    <= bus.mul_b;
            m_busy <= 1'b1;
            m_cnt  <= 5'd1;
        end else if (m_cnt <= 5'd16) begin
            if (m_cnt[0]) begin
                if (m_l[0]) m_h <= m_h + {1'b0, bus.mul_a};
            end else begin
                {m_h, m_l} <= 17'({m_h, m_l} >> 1);
            end
            m_cnt <= m_cnt + 5'd1;
            if (m_cnt == 5'd16) m_busy <= 1'b0;
        end
    end

    assign bus.mul_busy = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : m_busy;
    assign bus.mul_hreg = m_h;
    assign bus.mul_lreg = m_l;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one grant-to-done operation; returns at the negedge inside the done cycle.
    task automatic do_op(input string tag, input logic [3:0] eg, input logic [7:0] ea,
                         input logic [7:0] eb, input logic [15:0] er, input logic ee,
                         input int el, input int drop_at);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) begin
                check({tag, ".gnt"},   32'(bus.gnt),   32'(eg));
                check({tag, ".mul_a"}, 32'(bus.mul_a), 32'(ea));
                check({tag, ".mul_b"}, 32'(bus.mul_b), 32'(eb));
                check({tag, ".done_lo"}, 32'(bus.done), 32'd0);
            end
            if (cyc == 10 && el > 10) check({tag, ".gnt_hold"}, 32'(bus.gnt), 32'(eg));
            if (drop_at > 0 && cyc == drop_at) begin
                bus.req   = '0;
                bus.req_a = ~bus.req_a;
                bus.req_b = ~bus.req_b;
            end
            if (bus.done != '0) seen = 1'b1;
        end
        check({tag, ".latency"}, 32'(cyc - 1),  32'(el));
        check({tag, ".done"},    32'(bus.done), 32'(eg));
        check({tag, ".result"},  32'(bus.result), 32'(er));
        check({tag, ".err"},     32'(bus.err),  32'(ee));
        check({tag, ".gap"},     32'(bus.gnt),  32'd0);
    endtask

    initial begin
        bus.req   = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        repeat (3) @(negedge clk);
        check("rst.gnt",   32'(bus.gnt),       32'd0);
        check("rst.done",  32'(bus.done),      32'd0);
        check("rst.err",   32'(bus.err),       32'd0);
        check("rst.result",32'(bus.result),    32'd0);
        check("rst.start", 32'(bus.mul_start), 32'd0);
        check("rst.busy",  32'(bus.ctrl_busy), 32'd0);
        check("rst.mul_a", 32'(bus.mul_a),     32'd0);
        rst = 1'b0;
        @(negedge clk);

        set_slot(0, 8'hFF, 8'hFF);
        bus.req = 4'b0001;
        do_op("ff_ff", 4'b0001, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 20, 0);
        bus.req = '0;
        @(negedge clk);
        check("ff_ff.one_pulse", 32'(bus.done), 32'd0);
        check("ff_ff.idle",      32'(bus.ctrl_busy), 32'd0);

        set_slot(0, 8'h00, 8'h5A);
        bus.req = 4'b0001;
        do_op("zero", 4'b0001, 8'h00, 8'h5A, 16'h0000, 1'b0, 20, 0);
        bus.req = '0;
        @(negedge clk);

        set_slot(0, 8'h01, 8'hC3);
        bus.req = 4'b0001;
        do_op("ident", 4'b0001, 8'h01, 8'hC3, 16'h00C3, 1'b0, 20, 0);
        bus.req = '0;

        pulse_reset();
        for (int i = 0; i < 4; i++) set_slot(i, 8'(i + 2), 8'h10);
        bus.req = 4'b1111;
        do_op("rr0", 4'b0001, 8'h02, 8'h10, 16'h0020, 1'b0, 20, 0);
        do_op("rr1", 4'b0010, 8'h03, 8'h10, 16'h0030, 1'b0, 20, 0);
        do_op("rr2", 4'b0100, 8'h04, 8'h10, 16'h0040, 1'b0, 20, 0);
        do_op("rr3", 4'b1000, 8'h05, 8'h10, 16'h0050, 1'b0, 20, 0);
        do_op("rr4", 4'b0001, 8'h02, 8'h10, 16'h0020, 1'b0, 20, 0);
        bus.req = '0;
        @(negedge clk);

        set_slot(2, 8'h37, 8'h0B);
        bus.req = 4'b0100;
        do_op("drop", 4'b0100, 8'h37, 8'h0B, 16'h025D, 1'b0, 20, 4);
        bus.req = '0;
        @(negedge clk);

        mode = 1;
        set_slot(0, 8'h03, 8'h03);
        bus.req = 4'b0001;
        do_op("wd_hi", 4'b0001, 8'h03, 8'h03, 16'h0000, 1'b1, 6, 0);
        bus.req = '0;
        @(negedge clk);
        check("wd_hi.err_pulse", 32'(bus.err), 32'd0);

        mode = 2;
        set_slot(1, 8'h07, 8'h09);
        bus.req = 4'b0010;
        do_op("wd_run", 4'b0010, 8'h07, 8'h09, 16'h0000, 1'b1, 23, 0);
        bus.req = '0;
        @(negedge clk);
        mode = 0;

        set_slot(1, 8'h0F, 8'h0F);
        bus.req = 4'b0010;
        do_op("post_wd", 4'b0010, 8'h0F, 8'h0F, 16'h00E1, 1'b0, 20, 0);
        bus.req = '0;
        @(negedge clk);

        set_slot(0, 8'h12, 8'h34);
        bus.req = 4'b0001;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("midrun.start", 32'(bus.mul_start), 32'd1);
        check("midrun.busy",  32'(bus.ctrl_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrun.gnt",   32'(bus.gnt),       32'd0);
        check("midrun.done",  32'(bus.done),      32'd0);
        check("midrun.err",   32'(bus.err),       32'd0);
        check("midrun.start0",32'(bus.mul_start), 32'd0);
        check("midrun.cbusy", 32'(bus.ctrl_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("restart", 4'b0001, 8'h12, 8'h34, 16'h03A8, 1'b0, 20, 0);
        bus.req = '0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Round-robin scheduler that shares one 8-bit shift-add multiplier (S_multi) among NREQ requesters in the RSA datapath.
- For each request it latches the operands and sequences the multiplier's active-low start/clear line, then tracks busy to completion.
- It captures the 2W-bit product and returns it to the granted requester with a one-cycle done pulse.
- It watchdogs the multiplier handshake and flags a fault if the handshake stalls.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand width; must match the multiplier's Bit.
- TMO_HI, 4, cycles allowed in WAIT_HI for mul_busy to rise.
- TMO_RUN, 2*W+4, cycles allowed in RUN for mul_busy to fall.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_a  in  NREQ*W  flattened operand A; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  flattened operand B, same packing as req_a.
- gnt  out  NREQ  one-hot grant, held for the whole operation.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle fault pulse, coincident with done.
- result  out  2*W  product; held until the next completion.
- ctrl_busy  out  1  high in any state other than IDLE.
- mul_start  out  1  multiplier start; low clears/readies the multiplier, high runs it.
- mul_a, mul_b  out  W  latched operands to the multiplier.
- mul_busy  in  1  multiplier busy.
- mul_hreg  in  W+1  multiplier high register.
- mul_lreg  in  W  multiplier low register.

Behaviour:
- Reset values: state=IDLE, gnt=0, done=0, err=0, result=0, mul_start=0, mul_a=mul_b=0, timer=0, rr_last=NREQ-1 (requester 0 has first priority).
- All outputs are registered.
- States: IDLE, CLEAR, WAIT_HI, RUN, RESP.
- IDLE:
  - mul_start=0.
  - If any req is set, pick the first set bit searching upward from rr_last+1 with wrap.
  - Set gnt one-hot, latch mul_a/mul_b from that slot, set rr_last to the winner, go to CLEAR.
- CLEAR: mul_start held 0 for one full cycle so the multiplier resets its count. Then set mul_start<=1, timer<=0, and go to WAIT_HI.
- WAIT_HI:
  - If mul_busy=1, go to RUN with timer<=0.
  - Otherwise timer increments; at timer==TMO_HI-1 go to RESP with fault.
- RUN:
  - If mul_busy=0, capture result={mul_hreg[W-1:0], mul_lreg} and go to RESP.
  - Otherwise timer increments; at timer==TMO_RUN-1 go to RESP with fault.
- RESP (one cycle):
  - done[granted]=1, err=fault.
  - mul_start<=0.
  - gnt cleared on exit, then go to IDLE.
- Fault: result is forced to 0 and err=1 alongside done. The multiplier is cleared by the return of mul_start to 0.
- Latency with an 8-bit S_multi (one Init cycle, then 16 add/shift cycles): if req is sampled in IDLE at edge 0, done is high in the cycle after edge 20.
- Back-to-back requests: at least one IDLE cycle separates consecutive grants.
- gnt never has more than one bit set.
- Operands are latched at grant, so req_a/req_b may change after gnt.
- If req drops mid-operation, the operation still completes and done is still pulsed to that requester.
- mul_hreg[W] is ignored; it is always 0 for W x W operands.
- A new req arriving while not in IDLE is held pending by the requester. It is not lost, because req is level-sensitive.
- Async rst mid-operation: return to the reset values immediately. mul_start=0 also clears the multiplier, and no done is issued.

Test Plan:
- Single request: req=0001, A=0xFF, B=0xFF -> gnt=0001; done[0] pulses once, 20 cycles after sampling; result=0xFE01; err=0.
- Zero/identity: A=0x00, B=0x5A -> result=0x0000. Then A=0x01, B=0xC3 -> result=0x00C3.
- Round-robin: req=1111 held, each with distinct operands (e.g. A=i+2, B=0x10) -> grant order 0,1,2,3,0; each result correct; one IDLE cycle between grants.
- Early withdrawal: req[2] drops 3 cycles after gnt=0100, operands changed at the same time -> done[2] still pulses and result uses the latched operands.
- Watchdog: mul_busy tied 0 -> err+done pulse after CLEAR plus TMO_HI cycles, result=0. mul_busy tied 1 -> fault after TMO_RUN cycles in RUN.
- Reset mid-RUN: assert rst 8 cycles into RUN -> gnt, done, err and mul_start go to 0 immediately. After release, req=0001 restarts and completes with the correct product.
